img_frame_source: RTL

//  Frame transmitter for the vsync/href/gray pixel-stream interface consumed by the image-processing

---
 rtl/img_stream_pkg.sv | 26 ++
 rtl/img_frame_timing.sv | 129 ++++++++++++
 rtl/img_frame_source.sv | 106 ++++++++++
 3 files changed

// File: rtl/img_stream_pkg.sv
// Shared types and constants for the vsync/href/gray pixel-stream blocks.
package img_stream_pkg;

  // Sequencer phases of one replayed frame.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2,
    POST   = 2'd3
  } fsm_state_e;

  // Stages between a RAM read issue and the pixel leaving the block:
  // one cycle of RAM latency plus the output gray register.
  localparam int PIPE_LAT = 2;

  // Gray pixel width.
  localparam int PIX_W = 8;

  // Largest of three values; sizes a counter shared by several phases.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/img_frame_timing.sv
// Frame sequencer: walks BLANK/ACTIVE rows and the POST tail, issuing one RAM
// read per ACTIVE cycle at a linear row-major address.
module img_frame_timing
  import img_stream_pkg::*;
#(
  parameter int IMG_HDISP = 512,
  parameter int IMG_VDISP = 512,
  parameter int H_BLANK   = 10,
  parameter int V_POST    = 1,
  parameter int ADDR_W    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              vsync_o,
  output logic              href_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  // Only one phase runs at a time, so blank, column and post cycles share a
  // single phase counter sized for the longest of them.
  localparam int CNT_MAX = max3(H_BLANK, IMG_HDISP, V_POST);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ROW_W   = $clog2(IMG_VDISP + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(IMG_HDISP - 1);
  localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(V_POST - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_VDISP - 1);

  fsm_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;
  logic              vsync_q;
  logic              href_q;
  logic              rd_en_q;
  logic              last_q;

  // Sequencer with registered stream controls; abort returns to IDLE at once.
  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values and the block simulates like the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      rd_en_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      rd_en_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            row_q   <= '0;
            vsync_q <= 1'b1;
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            href_q  <= 1'b1;
            rd_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (cnt_q == COL_LAST) begin
            cnt_q   <= '0;
            href_q  <= 1'b0;
            rd_en_q <= 1'b0;
            if (row_q == ROW_LAST) begin
              // Last pixel of the frame issued: rewind the address here so
              // it can never step past the final pixel.
              state_q <= POST;
              row_q   <= '0;
              addr_q  <= '0;
              last_q  <= (V_POST == 1);
            end else begin
              state_q <= BLANK;
              row_q   <= row_q + ROW_W'(1);
              addr_q  <= addr_q + ADDR_W'(1);
            end
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        POST: begin
          if (cnt_q == POST_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            last_q <= (cnt_q + CNT_W'(1)) == POST_LAST;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vsync_o = vsync_q;
  assign href_o  = href_q;
  assign rd_en_o = rd_en_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;

endmodule

// File: rtl/img_frame_source.sv
// Frame source: replays a stored gray frame from a synchronous RAM as a
// vsync/href/gray pixel stream, one pixel per clock, row-major.
module img_frame_source
  import img_stream_pkg::*;
#(
  parameter int IMG_HDISP = 512,
  parameter int IMG_VDISP = 512,
  parameter int H_BLANK   = 10,
  parameter int V_POST    = 1,
  parameter int ADDR_W    = 18   // 2**ADDR_W must cover IMG_HDISP*IMG_VDISP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              post_img_vsync,
  output logic              post_img_href,
  output logic [PIX_W-1:0]  post_img_gray
);

  logic              tim_vsync;
  logic              tim_href;
  logic              tim_last;
  logic              start_acc;

  logic [PIPE_LAT-1:0] vsync_pipe_q;
  logic [PIPE_LAT-1:0] href_pipe_q;
  logic [PIPE_LAT-1:0] last_pipe_q;
  logic [PIX_W-1:0]    gray_q;
  logic                done_q;

  // A frame stays busy until its tail has drained out of the alignment pipe;
  // start is ignored until then, and abort always wins over start.
  assign busy      = tim_vsync | (|vsync_pipe_q);
  assign start_acc = start & ~busy & ~abort;

  img_frame_timing #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .H_BLANK   (H_BLANK),
    .V_POST    (V_POST),
    .ADDR_W    (ADDR_W)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_acc),
    .abort_i (abort),
    .vsync_o (tim_vsync),
    .href_o  (tim_href),
    .rd_en_o (mem_rd_en),
    .addr_o  (mem_rd_addr),
    .last_o  (tim_last)
  );

  // Delay sync flags to meet the RAM data; abort empties the pipe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_pipe_q <= '0;
      href_pipe_q  <= '0;
      last_pipe_q  <= '0;
    end else if (abort) begin
      vsync_pipe_q <= '0;
      href_pipe_q  <= '0;
      last_pipe_q  <= '0;
    end else begin
      vsync_pipe_q <= {vsync_pipe_q[PIPE_LAT-2:0], tim_vsync};
      href_pipe_q  <= {href_pipe_q[PIPE_LAT-2:0], tim_href};
      last_pipe_q  <= {last_pipe_q[PIPE_LAT-2:0], tim_last};
    end
  end

  // Output pixel register; together with the RAM latency this lines a pixel
  // up with the href delayed through the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q <= '0;
    end else if (abort) begin
      gray_q <= '0;
    end else begin
      gray_q <= mem_rd_data;
    end
  end

  // Frame-end pulse in the first cycle after the last vsync-high output cycle;
  // an aborted frame clears the last flag from the pipe and never pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (abort) begin
      done_q <= 1'b0;
    end else begin
      done_q <= last_pipe_q[PIPE_LAT-1];
    end
  end

  assign post_img_vsync = vsync_pipe_q[PIPE_LAT-1];
  assign post_img_href  = href_pipe_q[PIPE_LAT-1];
  assign post_img_gray  = gray_q;
  assign done           = done_q;

endmodule
